// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types, constants and round-robin pick function for axis_pkt_arbiter
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 32;
  localparam int MAX_PORTS = 16;

  // First set bit of req at or above ptr, wrapping at n-1; returns ptr when req is empty.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic [3:0] idx;
    int         j;
    idx = ptr;
    j   = 0;
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j[3:0]]) idx = 4'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// rtl/axis_rr_picker.sv - combinational round-robin priority encoder
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  logic [3:0] pick;

  assign pick  = rr_pick(16'(req), 4'(ptr), NUM_PORTS);
  assign idx   = IDX_W'(pick);
  assign found = |req;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular round-robin AXI-Stream arbiter
// Per-port completed-packet counters exist only when AXIS_ARB_PKT_CNT_EN is defined.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 128,
  parameter int NUM_PORTS  = 4,
  parameter int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_PORTS-1:0]             s_tvalid,
  output logic [NUM_PORTS-1:0]             s_tready,
  input  logic [NUM_PORTS-1:0]             s_tlast,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  output logic [DATA_WIDTH/8-1:0]          m_tkeep,
  output logic [USER_WIDTH-1:0]            m_tuser,
  input  logic                             m_tready,
  output logic                             grant_valid,
  output logic [IDX_W-1:0]                 grant_idx
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]   pkt_cnt
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             pkt_done;

  axis_rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req  (s_tvalid),
    .ptr  (rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_done    = 1'b0;
    s_tready    = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    m_tuser     = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        m_tvalid              = s_tvalid[grant_idx_q];
        m_tlast               = s_tlast[grant_idx_q];
        m_tdata               = s_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep               = s_tkeep[grant_idx_q*KEEP_W +: KEEP_W];
        m_tuser               = s_tuser[grant_idx_q*USER_WIDTH +: USER_WIDTH];
        s_tready[grant_idx_q] = m_tready;
        pkt_done              = m_tvalid & m_tready & m_tlast;
        if (pkt_done) begin
          // The port just served drops to lowest priority for the next pick.
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + IDX_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = grant_idx_q;

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_PORTS*PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_done) begin
      pkt_cnt_d[grant_idx_q*PKT_CNT_W +: PKT_CNT_W] =
        pkt_cnt_q[grant_idx_q*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - self-checking bench for axis_pkt_arbiter (AXIS_ARB_PKT_CNT_EN optional)
module tb_axis_pkt_arbiter;
  import axis_arb_pkg::*;

  localparam int DW = 64;
  localparam int UW = 128;
  localparam int NP = 4;
  localparam int IW = 2;
  localparam int KW = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP*UW-1:0]  s_tuser;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NP*PKT_CNT_W-1:0] pkt_cnt;
`endif

  axis_pkt_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .NUM_PORTS(NP), .IDX_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
    .m_tuser(m_tuser), .m_tready(m_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
`ifdef AXIS_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          rstn;
    logic [NP-1:0] vld;
    logic [NP-1:0] lst;
    logic          mrdy;
    logic          e_gv;
    logic [IW-1:0] e_gidx;
    logic          e_mv;
    logic          e_ml;
    logic [NP-1:0] e_sr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] model_cnt[NP];

  function automatic vec_t mk(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                              input logic mrdy, input logic gv, input logic [1:0] gidx,
                              input logic mv, input logic ml, input logic [3:0] sr);
    vec_t v;
    v.rstn = rstn; v.vld = vld; v.lst = lst; v.mrdy = mrdy;
    v.e_gv = gv; v.e_gidx = gidx; v.e_mv = mv; v.e_ml = ml; v.e_sr = sr;
    return v;
  endfunction

  function automatic logic [DW-1:0] tdata_of(input int j, input int p);
    return {32'(j), 32'(p)};
  endfunction
  function automatic logic [KW-1:0] tkeep_of(input int p);
    logic [KW-1:0] one;
    one = KW'(1);
    return one << p;
  endfunction
  function automatic logic [UW-1:0] tuser_of(input int j, input int p);
    return {64'(p + 32'h55), 64'(j)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_data(input int j);
    for (int p = 0; p < NP; p++) begin
      s_tdata[p*DW +: DW] = tdata_of(j, p);
      s_tkeep[p*KW +: KW] = tkeep_of(p);
      s_tuser[p*UW +: UW] = tuser_of(j, p);
    end
  endtask

`ifdef AXIS_ARB_PKT_CNT_EN
  function automatic logic [127:0] model_cnt_flat();
    logic [127:0] f;
    for (int p = 0; p < NP; p++) f[p*32 +: 32] = model_cnt[p];
    return f;
  endfunction
`endif

  int order[$];
  int exp_order[7];
  int rem0, rem3;

  initial begin
    aresetn = 1'b0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    for (int p = 0; p < NP; p++) model_cnt[p] = '0;

    //        rstn vld      lst      rdy  gv  gidx mv  ml  sr
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000)); // 0 reset state
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000)); // 1 arbitration cycle
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 1, 2, 1, 0, 4'b0100)); // 2 beat 1
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 1, 2, 1, 0, 4'b0100)); // 3 beat 2
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 2, 1, 1, 4'b0100)); // 4 beat 3 tlast
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 2, 0, 0, 4'b0000)); // 5 grant dropped
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 2, 0, 0, 4'b0000)); // 6 reset rr_ptr
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000)); // 7 all ports 1-beat
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 0, 1, 1, 4'b0001));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 1, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 2, 1, 1, 4'b0100));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 2, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 3, 1, 1, 4'b1000));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 3, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 0, 1, 1, 4'b0001)); // 16 wraps to 0
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000)); // 17 port 1 backpressure
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 1, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 1, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 1, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b1011, 4'b0000, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1011, 4'b0010, 1, 1, 1, 1, 1, 4'b0010)); // 24 beat 4 tlast
    vecs.push_back(mk(1, 4'b1001, 4'b0000, 1, 0, 1, 0, 0, 4'b0000)); // 25 ptr=2 -> port 3
    vecs.push_back(mk(1, 4'b1001, 4'b1000, 1, 1, 3, 1, 1, 4'b1000));
    vecs.push_back(mk(1, 4'b1001, 4'b0000, 1, 0, 3, 0, 0, 4'b0000)); // 27 ptr=0 -> port 0
    vecs.push_back(mk(1, 4'b1001, 4'b0000, 1, 1, 0, 1, 0, 4'b0001)); // 28 port 0 beat 1
    for (int g = 0; g < 5; g++)                                      // 29-33 upstream gap
      vecs.push_back(mk(1, 4'b1000, 4'b0000, 1, 1, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(1, 4'b1001, 4'b0001, 1, 1, 0, 1, 1, 4'b0001)); // 34 port 0 tlast
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 1, 1, 3, 1, 1, 4'b1000)); // 36 port 3 served after
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 3, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 3, 0, 0, 4'b0000)); // 38 reset mid-packet
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 1, 2, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 1, 2, 1, 0, 4'b0100)); // 40 reset during beat 2
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000)); // 41 back in IDLE
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 2, 1, 1, 4'b0100));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 2, 0, 0, 4'b0000));

    repeat (2) @(posedge aclk);
    for (int j = 0; j < vecs.size(); j++) begin
      #1;
      aresetn  = vecs[j].rstn;
      s_tvalid = vecs[j].vld;
      s_tlast  = vecs[j].lst;
      m_tready = vecs[j].mrdy;
      drive_data(j);
      @(negedge aclk);
      check($sformatf("v%0d grant_valid", j), 128'(grant_valid), 128'(vecs[j].e_gv));
      check($sformatf("v%0d grant_idx", j), 128'(grant_idx), 128'(vecs[j].e_gidx));
      check($sformatf("v%0d m_tvalid", j), 128'(m_tvalid), 128'(vecs[j].e_mv));
      check($sformatf("v%0d m_tlast", j), 128'(m_tlast), 128'(vecs[j].e_ml));
      check($sformatf("v%0d s_tready", j), 128'(s_tready), 128'(vecs[j].e_sr));
      check($sformatf("v%0d m_tdata", j), 128'(m_tdata),
            vecs[j].e_gv ? 128'(tdata_of(j, int'(vecs[j].e_gidx))) : 128'(0));
      check($sformatf("v%0d m_tkeep", j), 128'(m_tkeep),
            vecs[j].e_gv ? 128'(tkeep_of(int'(vecs[j].e_gidx))) : 128'(0));
      check($sformatf("v%0d m_tuser", j), m_tuser,
            vecs[j].e_gv ? tuser_of(j, int'(vecs[j].e_gidx)) : 128'(0));
`ifdef AXIS_ARB_PKT_CNT_EN
      check($sformatf("v%0d pkt_cnt", j), pkt_cnt, model_cnt_flat());
`endif
      if (!vecs[j].rstn)
        for (int p = 0; p < NP; p++) model_cnt[p] = '0;
      else if (vecs[j].e_mv && vecs[j].mrdy && vecs[j].e_ml)
        model_cnt[vecs[j].e_gidx] = model_cnt[vecs[j].e_gidx] + 1;
      @(posedge aclk);
    end

    // Port 0 sends 2 and port 3 sends 5 single-beat packets, both requesting together.
    #1;
    aresetn = 1'b0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rem0 = 2; rem3 = 5;
    exp_order[0] = 0; exp_order[1] = 3; exp_order[2] = 0;
    for (int k = 3; k < 7; k++) exp_order[k] = 3;
    for (int cyc = 0; cyc < 60 && (rem0 > 0 || rem3 > 0); cyc++) begin
      s_tvalid = {rem3 > 0, 1'b0, 1'b0, rem0 > 0};
      s_tlast  = 4'b1001;
      drive_data(100 + cyc);
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        order.push_back(int'(grant_idx));
        if (grant_idx == 2'd0) rem0--;
        else if (grant_idx == 2'd3) rem3--;
      end
      @(posedge aclk);
      #1;
    end
    s_tvalid = '0; s_tlast = '0;
    check("seq packet count", 128'(order.size()), 128'(7));
    for (int k = 0; k < 7; k++)
      check($sformatf("seq order[%0d]", k), (k < order.size()) ? 128'(order[k]) : 128'hdead,
            128'(exp_order[k]));
    @(negedge aclk);
    check("seq end grant_valid", 128'(grant_valid), 128'(0));
`ifdef AXIS_ARB_PKT_CNT_EN
    check("pkt_cnt[0]", 128'(pkt_cnt[0*32 +: 32]), 128'(2));
    check("pkt_cnt[1]", 128'(pkt_cnt[1*32 +: 32]), 128'(0));
    check("pkt_cnt[2]", 128'(pkt_cnt[2*32 +: 32]), 128'(0));
    check("pkt_cnt[3]", 128'(pkt_cnt[3*32 +: 32]), 128'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
